// File: rtl/usb3_descramble.sv
// USB 3.0 RX descrambler with SKP stripping and dense 4-symbol repacking.
// Stage 1 descrambles and classifies lanes; stage 2 repacks kept symbols.
module usb3_descramble #(
   parameter logic [15:0] LFSR_SEED = 16'hFFFF,
   parameter int unsigned BUF_SYMS  = 8
) (
   input  logic        local_clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [31:0] in_data,
   input  logic [3:0]  in_datak,
   input  logic        in_valid,
   output logic [31:0] out_data,
   output logic [3:0]  out_datak,
   output logic        out_valid,
   output logic [2:0]  skp_stripped
);

   localparam logic [7:0] SymCom = 8'hBC;
   localparam logic [7:0] SymSkp = 8'h3C;

   // Eight serial steps of the Galois LFSR; returns {next_state, scramble_byte}.
   function automatic logic [23:0] lfsr_byte(input logic [15:0] s);
      logic [15:0] st;
      logic [7:0]  b;
      st = s;
      b  = '0;
      for (int i = 0; i < 8; i++) begin
         b[i] = st[15];
         st   = {st[14:0], 1'b0} ^ (st[15] ? 16'h0039 : 16'h0000);
      end
      return {st, b};
   endfunction

   logic [15:0] lfsr_q, lfsr_d;
   logic [31:0] s1_data_q, s1_data_d;
   logic [3:0]  s1_datak_q, s1_datak_d;
   logic [3:0]  s1_keep_q, s1_keep_d;
   logic        s1_valid_q, s1_valid_d;
   logic        s1_bypass_q, s1_bypass_d;
   logic [2:0]  skp_q, skp_d;

   logic [8:0]  buf_q [BUF_SYMS];
   logic [8:0]  buf_d [BUF_SYMS];
   logic [2:0]  cnt_q, cnt_d;
   logic [31:0] out_data_q, out_data_d;
   logic [3:0]  out_datak_q, out_datak_d;
   logic        out_valid_q, out_valid_d;

   logic [15:0] lfsr_v;
   logic [23:0] step;
   logic [7:0]  sym;
   logic        is_k;
   logic [3:0]  idx;

   // Stage 1: lane-ordered descramble, COM reseed, SKP freeze and keep mask.
   always_comb begin
      lfsr_d      = lfsr_q;
      s1_data_d   = in_data;
      s1_datak_d  = in_datak;
      s1_keep_d   = '0;
      s1_valid_d  = in_valid;
      s1_bypass_d = !enable;
      skp_d       = 3'd0;
      lfsr_v      = lfsr_q;
      step        = '0;
      sym         = '0;
      is_k        = 1'b0;
      if (!enable) begin
         lfsr_d    = LFSR_SEED;
         s1_keep_d = {4{in_valid}};
      end else if (in_valid) begin
         for (int l = 0; l < 4; l++) begin
            sym  = in_data[31-8*l -: 8];
            is_k = in_datak[3-l];
            if (is_k && sym == SymCom) begin
               lfsr_v         = LFSR_SEED;
               s1_keep_d[3-l] = 1'b1;
            end else if (is_k && sym == SymSkp) begin
               skp_d = skp_d + 3'd1;
            end else begin
               step = lfsr_byte(lfsr_v);
               if (!is_k) begin
                  s1_data_d[31-8*l -: 8] = sym ^ step[7:0];
               end
               lfsr_v         = step[23:8];
               s1_keep_d[3-l] = 1'b1;
            end
         end
         lfsr_d = lfsr_v;
      end
   end

   // Stage 2: append kept symbols, emit the oldest four once available.
   always_comb begin
      buf_d       = buf_q;
      cnt_d       = cnt_q;
      out_valid_d = 1'b0;
      out_data_d  = out_data_q;
      out_datak_d = out_datak_q;
      idx         = {1'b0, cnt_q};
      if (s1_bypass_q) begin
         // Bypass drops any leftovers so re-enable starts on an empty buffer.
         cnt_d       = '0;
         out_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            out_data_d  = s1_data_q;
            out_datak_d = s1_datak_q;
         end
      end else begin
         for (int l = 0; l < 4; l++) begin
            if (s1_keep_q[3-l]) begin
               buf_d[idx[2:0]] = {s1_datak_q[3-l], s1_data_q[31-8*l -: 8]};
               idx             = idx + 4'd1;
            end
         end
         if (idx >= 4'd4) begin
            out_valid_d = 1'b1;
            for (int l = 0; l < 4; l++) begin
               out_data_d[31-8*l -: 8] = buf_d[l][7:0];
               out_datak_d[3-l]        = buf_d[l][8];
            end
            for (int i = 0; i + 4 < BUF_SYMS; i++) begin
               buf_d[i] = buf_d[i+4];
            end
            idx = idx - 4'd4;
         end
         cnt_d = idx[2:0];
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge local_clk) begin
      if (reset) begin
         lfsr_q      <= LFSR_SEED;
         s1_data_q   <= '0;
         s1_datak_q  <= '0;
         s1_keep_q   <= '0;
         s1_valid_q  <= 1'b0;
         s1_bypass_q <= 1'b0;
         skp_q       <= '0;
         cnt_q       <= '0;
         out_data_q  <= '0;
         out_datak_q <= '0;
         out_valid_q <= 1'b0;
         for (int i = 0; i < BUF_SYMS; i++) begin
            buf_q[i] <= '0;
         end
      end else begin
         lfsr_q      <= lfsr_d;
         s1_data_q   <= s1_data_d;
         s1_datak_q  <= s1_datak_d;
         s1_keep_q   <= s1_keep_d;
         s1_valid_q  <= s1_valid_d;
         s1_bypass_q <= s1_bypass_d;
         skp_q       <= skp_d;
         cnt_q       <= cnt_d;
         out_data_q  <= out_data_d;
         out_datak_q <= out_datak_d;
         out_valid_q <= out_valid_d;
         buf_q       <= buf_d;
      end
   end

   assign out_data     = out_data_q;
   assign out_datak    = out_datak_q;
   assign out_valid    = out_valid_q;
   assign skp_stripped = skp_q;

endmodule

// File: tb/tb_usb3_descramble.sv
// Bench for usb3_descramble: symbol-queue reference model checked every
// cycle, plus literal expectations for the known scrambler sequence.
module tb_usb3_descramble;

   localparam logic [15:0] Seed = 16'hFFFF;

   logic        clk = 1'b0;
   logic        reset, enable, in_valid;
   logic [31:0] in_data;
   logic [3:0]  in_datak;
   logic [31:0] out_data;
   logic [3:0]  out_datak;
   logic        out_valid;
   logic [2:0]  skp_stripped;

   int checks = 0;
   int errors = 0;

   usb3_descramble #(.LFSR_SEED(Seed), .BUF_SYMS(8)) dut (
      .local_clk   (clk),
      .reset       (reset),
      .enable      (enable),
      .in_data     (in_data),
      .in_datak    (in_datak),
      .in_valid    (in_valid),
      .out_data    (out_data),
      .out_datak   (out_datak),
      .out_valid   (out_valid),
      .skp_stripped(skp_stripped)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   // Serial USB3 scrambler step over one byte, LSB first: {next_state, byte}.
   function automatic logic [23:0] scr(input logic [15:0] s);
      logic [15:0] st;
      logic [7:0]  b;
      st = s;
      b  = '0;
      for (int i = 0; i < 8; i++) begin
         b[i] = st[15];
         st   = {st[14:0], 1'b0} ^ (st[15] ? 16'h0039 : 16'h0000);
      end
      return {st, b};
   endfunction

   // Reference model: symbol stream into a queue, pop four when available.
   logic [15:0] m_lfsr;
   logic [8:0]  m_q [$];
   logic        pend_v, exp_v, exp_zero, model_ok;
   logic [31:0] pend_d, exp_d;
   logic [3:0]  pend_k, exp_k;
   logic [2:0]  exp_skp;

   initial begin
      logic [7:0]  sym;
      logic        kk;
      logic [23:0] r;
      logic [8:0]  e;
      model_ok = 1'b0;
      pend_v = 1'b0; pend_d = '0; pend_k = '0;
      exp_v = 1'b0; exp_d = '0; exp_k = '0; exp_skp = '0; exp_zero = 1'b0;
      m_lfsr = Seed;
      forever begin
         @(posedge clk);
         if (reset) begin
            m_q.delete();
            m_lfsr = Seed;
            pend_v = 1'b0;
            exp_v = 1'b0; exp_skp = '0; exp_zero = 1'b1;
            model_ok = 1'b1;
         end else begin
            exp_zero = 1'b0;
            exp_v = pend_v; exp_d = pend_d; exp_k = pend_k;
            exp_skp = '0;
            pend_v = 1'b0;
            if (!enable) begin
               m_q.delete();
               m_lfsr = Seed;
               pend_v = in_valid; pend_d = in_data; pend_k = in_datak;
            end else if (in_valid) begin
               for (int l = 0; l < 4; l++) begin
                  sym = in_data[31-8*l -: 8];
                  kk  = in_datak[3-l];
                  if (kk && sym == 8'hBC) begin
                     m_q.push_back({1'b1, sym});
                     m_lfsr = Seed;
                  end else if (kk && sym == 8'h3C) begin
                     exp_skp = exp_skp + 3'd1;
                  end else begin
                     r = scr(m_lfsr);
                     m_q.push_back({kk, kk ? sym : sym ^ r[7:0]});
                     m_lfsr = r[23:8];
                  end
               end
               if (m_q.size() >= 4) begin
                  pend_v = 1'b1;
                  for (int l = 0; l < 4; l++) begin
                     e = m_q.pop_front();
                     pend_d[31-8*l -: 8] = e[7:0];
                     pend_k[3-l] = e[8];
                  end
               end
            end
         end
      end
   end

   // Output logs for directed literal checks.
   logic [31:0] log_d [$];
   logic [3:0]  log_k [$];
   logic [2:0]  skp_log [$];

   // Per-cycle comparison against the model, sampled away from the clock edge.
   initial begin
      forever begin
         @(negedge clk);
         if (model_ok) begin
            chk("out_valid", {31'b0, out_valid}, {31'b0, exp_v});
            if (exp_v) begin
               chk("out_data", out_data, exp_d);
               chk("out_datak", {28'b0, out_datak}, {28'b0, exp_k});
            end
            if (exp_zero) begin
               chk("rst_data", out_data, 32'h0);
               chk("rst_datak", {28'b0, out_datak}, 32'h0);
            end
            chk("skp_stripped", {29'b0, skp_stripped}, {29'b0, exp_skp});
            if (out_valid) begin
               log_d.push_back(out_data);
               log_k.push_back(out_datak);
            end
            if (skp_stripped != 3'd0) skp_log.push_back(skp_stripped);
         end
      end
   end

   task automatic drive(input logic [31:0] d, input logic [3:0] k, input logic v);
      @(negedge clk);
      in_data = d; in_datak = k; in_valid = v;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(32'h0, 4'h0, 1'b0);
   endtask

   task automatic clear_logs();
      @(posedge clk);
      log_d.delete(); log_k.delete(); skp_log.delete();
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; in_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   logic [8:0] tx_syms [$];
   logic [8:0] exp_syms [$];

   initial begin
      logic [15:0] s;
      logic [23:0] r;
      logic [31:0] w;
      logic [3:0]  wk;
      int n4, bad, skp_out;

      reset = 1'b1; enable = 1'b1; in_valid = 1'b0; in_data = '0; in_datak = '0;
      repeat (3) @(negedge clk);
      chk("reset_valid", {31'b0, out_valid}, 32'h0);
      chk("reset_data", out_data, 32'h0);
      chk("reset_skp", {29'b0, skp_stripped}, 32'h0);
      reset = 1'b0;

      // COM then zeros: scrambler keystream FF 17 C0 14 B2 E7 02.
      clear_logs();
      drive(32'hBC000000, 4'b1000, 1'b1);
      drive(32'h00000000, 4'b0000, 1'b1);
      idle(4);
      chk("t1_words", log_d.size(), 2);
      chk("t1_w0", log_d[0], 32'hBCFF17C0);
      chk("t1_k0", {28'b0, log_k[0]}, 32'h8);
      chk("t1_w1", log_d[1], 32'h14B2E702);
      chk("t1_k1", {28'b0, log_k[1]}, 32'h0);

      // Two trailing SKPs are stripped and later symbols shift up.
      clear_logs();
      drive(32'hBC003C3C, 4'b1011, 1'b1);
      drive(32'h00000000, 4'b0000, 1'b1);
      drive(32'h00000000, 4'b0000, 1'b1);
      idle(4);
      chk("t2_words", log_d.size(), 2);
      chk("t2_w0", log_d[0], 32'hBCFF17C0);
      chk("t2_k0", {28'b0, log_k[0]}, 32'h8);
      chk("t2_w1", log_d[1], 32'h14B2E702);
      chk("t2_skp_cnt", skp_log.size(), 1);
      chk("t2_skp", {29'b0, skp_log[0]}, 32'h2);

      // All-SKP words emit nothing and leave the LFSR frozen.
      clear_logs();
      repeat (8) drive(32'h3C3C3C3C, 4'b1111, 1'b1);
      idle(3);
      chk("t3_no_out", log_d.size(), 0);
      chk("t3_skp_cnt", skp_log.size(), 8);
      n4 = 0;
      foreach (skp_log[i]) if (skp_log[i] == 3'd4) n4++;
      chk("t3_skp4", n4, 8);
      drive(32'h00000000, 4'b0000, 1'b1);
      drive(32'h00000000, 4'b0000, 1'b1);
      idle(4);
      chk("t3_resume_words", log_d.size(), 2);

      // Loopback: scrambled random payload with inserted SKPs and idle gaps.
      do_reset();
      clear_logs();
      tx_syms.delete(); exp_syms.delete();
      tx_syms.push_back({1'b1, 8'hBC});
      exp_syms.push_back({1'b1, 8'hBC});
      s = Seed;
      for (int i = 0; i < 120; i++) begin
         if ($urandom_range(7) == 0) tx_syms.push_back({1'b1, 8'h3C});
         w[7:0] = 8'($urandom_range(255));
         exp_syms.push_back({1'b0, w[7:0]});
         r = scr(s);
         s = r[23:8];
         tx_syms.push_back({1'b0, w[7:0] ^ r[7:0]});
      end
      while (tx_syms.size() % 4 != 0) tx_syms.push_back({1'b1, 8'h3C});
      while (tx_syms.size() > 0) begin
         for (int l = 0; l < 4; l++) begin
            {wk[3-l], w[31-8*l -: 8]} = tx_syms.pop_front();
         end
         drive(w, wk, 1'b1);
         if ($urandom_range(3) == 0) idle(1);
      end
      idle(4);
      chk("lb_words", log_d.size() * 4, (exp_syms.size() / 4) * 4);
      bad = 0; skp_out = 0;
      foreach (log_d[i]) begin
         for (int l = 0; l < 4; l++) begin
            if (i * 4 + l < exp_syms.size()) begin
               if ({log_k[i][3-l], log_d[i][31-8*l -: 8]} != exp_syms[i*4+l]) bad++;
            end
            if (log_k[i][3-l] && log_d[i][31-8*l -: 8] == 8'h3C) skp_out++;
         end
      end
      chk("lb_bytes", bad, 0);
      chk("lb_no_skp", skp_out, 0);

      // Bypass: raw word out two clocks later.
      do_reset();
      enable = 1'b0;
      clear_logs();
      drive(32'h12345678, 4'b0000, 1'b1);
      idle(1);
      chk("byp_early", {31'b0, out_valid}, 32'h0);
      idle(1);
      chk("byp_valid", {31'b0, out_valid}, 32'h1);
      chk("byp_data", out_data, 32'h12345678);
      idle(2);
      chk("byp_words", log_d.size(), 1);
      chk("byp_k", {28'b0, log_k[0]}, 32'h0);

      // Reset with three symbols buffered, then restart on a COM word.
      enable = 1'b1;
      do_reset();
      clear_logs();
      drive(32'hBC00003C, 4'b1001, 1'b1);
      idle(2);
      chk("rst_buffered_none", log_d.size(), 0);
      @(negedge clk);
      reset = 1'b1; in_valid = 1'b0;
      @(negedge clk);
      chk("rst_mid_valid", {31'b0, out_valid}, 32'h0);
      reset = 1'b0;
      drive(32'hBC000000, 4'b1000, 1'b1);
      idle(4);
      chk("rst_after_words", log_d.size(), 1);
      chk("rst_after_w0", log_d[0], 32'hBCFF17C0);
      chk("rst_after_k0", {28'b0, log_k[0]}, 32'h8);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
